conv_layer_mem_host: RTL and testbench
======================================

Name: conv_layer_mem_host

Overview:
- Responder side of the convolution engine's memory/handshake interface.
- Holds the 64x64 input image RAM and answers iaddr with idata.
- Issues the one-cycle ready start pulse, then services the engine's layer-0 and layer-1 write/read traffic in two result RAMs.
- After the engine drops busy, streams both result RAMs out over a valid/ready dump port, so one block wraps the engine for system integration and for verification.

Parameters:
- IMG_AW, 12, image and layer-0 address width (4096 words)
- L1_AW, 10, layer-1 address width (1024 words)
- DW, 20, data word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ready  out  1  start pulse to engine
- busy  in  1  engine busy
- iaddr  in  12  image read address
- idata  out  20  image word
- cwr  in  1  layer write strobe
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  layer read strobe
- caddr_rd  in  12  layer read address
- cdata_rd  out  20  layer read data
- csel  in  3  bank select: 3'b001 = L0, 3'b011 = L1
- load_valid  in  1  image load word valid
- load_data  in  20  image load word
- load_full  out  1  all 4096 image words loaded
- go  in  1  start request
- dump_valid  out  1  dump word valid
- dump_ready  in  1  dump consumer ready
- dump_data  out  20  dump word
- dump_sel  out  1  0 = L0 word, 1 = L1 word
- dump_addr  out  12  address of dump word
- dump_last  out  1  final dump word (L1 address 1023)
- done  out  1  dump complete, sticky until reset
- wr_err  out  1  sticky illegal-write flag

Behaviour:
- States: LOAD, START, WAIT_BUSY, RUN, DUMP_L0, DUMP_L1, DONE.
- Reset:
  - state = LOAD; load counter = 0; dump pointer = 0.
  - ready, load_full, dump_valid, dump_sel, dump_last, done, wr_err all 0.
  - RAM contents are not cleared.
  - Reset mid-run or mid-dump aborts immediately to LOAD.
- LOAD:
  - Each load_valid writes load_data to image[load_cnt], then load_cnt increments.
  - At count 4096, load_full = 1, the counter wraps to 0, and further words overwrite from address 0.
  - load_valid in any other state is ignored.
  - go moves to START whether or not load_full is set.
- START: ready = 1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: waits for busy = 1, then RUN. busy already high on entry is accepted.
- RUN: busy = 0 sampled -> DUMP_L0.
- Image read: idata = image[iaddr], combinational, in every state.
- Layer write, on the clock edge when cwr = 1:
  - csel 3'b001: L0[caddr_wr] <= cdata_wr.
  - csel 3'b011: L1[caddr_wr[9:0]] <= cdata_wr. If caddr_wr[11:10] != 0, the write is dropped and wr_err is set.
  - Any other csel: write dropped and wr_err is set.
  - Writes are accepted in every state except DUMP_L0/DUMP_L1/DONE, where they are dropped and wr_err is set.
- Layer read: cdata_rd is combinational.
  - crd = 1 and csel 001: L0[caddr_rd].
  - crd = 1 and csel 011: L1[caddr_rd[9:0]].
  - Otherwise 0.
  - Read and write to the same address in the same cycle: cdata_rd shows the pre-write value; the new value is visible the next cycle.
- DUMP_L0 / DUMP_L1:
  - dump_valid = 1; dump_data = bank[ptr]; dump_addr = ptr; dump_sel = 0 for L0, 1 for L1.
  - ptr advances only when dump_valid && dump_ready. Outputs hold stable while dump_ready = 0.
  - After L0 ptr 4095 is accepted: ptr = 0, dump_sel = 1, go to DUMP_L1.
  - dump_last = 1 only with L1 ptr 1023. Its acceptance goes to DONE.
  - No gaps between words when dump_ready is held high.
- DONE: dump_valid = 0, done = 1. Only reset leaves DONE; go is ignored.

Test Plan:
- Reset, load 4096 words image[i] = i, pulse go -> load_full = 1 after the 4096th word; ready is high exactly one cycle after go; idata = 20'h00ABC when iaddr = 12'hABC.
- Drive cwr with csel 3'b001, caddr_wr 5, cdata_wr 20'h12345 while crd reads address 5 in the same cycle -> cdata_rd shows the old value that cycle and 20'h12345 the next.
- Write csel 3'b011, caddr_wr 12'h400 -> write dropped, wr_err = 1. Write csel 3'b010 -> dropped, wr_err stays 1.
- busy high for 100 cycles then low, dump_ready constantly 1 -> 5120 consecutive dump beats: L0 addresses 0..4095 with dump_sel = 0, then L1 addresses 0..1023 with dump_sel = 1; dump_last only on the final beat; done = 1 the cycle after.
- Toggle dump_ready randomly during the dump -> every word is emitted exactly once, in order, with outputs stable while stalled.
- Assert reset during DUMP_L1 at ptr 200 -> next cycle state is LOAD; dump_valid = 0; done = 0; load_full = 0; previously written L0 data is still readable through crd.

Source files
------------

// File: rtl/conv_layer_mem_host_if.sv
// Memory/handshake bundle between the convolution engine side (master)
// and the memory host (slave), including image load and result dump ports.
interface conv_layer_mem_host_if #(
  parameter int IMG_AW = 12,
  parameter int DW     = 20
);
  logic              ready;
  logic              busy;
  logic [IMG_AW-1:0] iaddr;
  logic [DW-1:0]     idata;
  logic              cwr;
  logic [IMG_AW-1:0] caddr_wr;
  logic [DW-1:0]     cdata_wr;
  logic              crd;
  logic [IMG_AW-1:0] caddr_rd;
  logic [DW-1:0]     cdata_rd;
  logic [2:0]        csel;
  logic              load_valid;
  logic [DW-1:0]     load_data;
  logic              load_full;
  logic              go;
  logic              dump_valid;
  logic              dump_ready;
  logic [DW-1:0]     dump_data;
  logic              dump_sel;
  logic [IMG_AW-1:0] dump_addr;
  logic              dump_last;
  logic              done;
  logic              wr_err;

  modport master (
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           load_valid, load_data, go, dump_ready,
    input  ready, idata, cdata_rd, load_full, dump_valid, dump_data,
           dump_sel, dump_addr, dump_last, done, wr_err
  );

  modport slave (
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           load_valid, load_data, go, dump_ready,
    output ready, idata, cdata_rd, load_full, dump_valid, dump_data,
           dump_sel, dump_addr, dump_last, done, wr_err
  );
endinterface

// File: rtl/conv_layer_mem_host.sv
// Memory host wrapped around the convolution engine: image RAM with a
// streaming loader, layer-0/layer-1 result RAMs, start handshake and a
// valid/ready dump of both result banks once the engine goes idle.
module conv_layer_mem_host #(
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10,
  parameter int DW     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_layer_mem_host_if.slave  bus
);

  localparam int IMG_DEPTH = 1 << IMG_AW;
  localparam int L1_DEPTH  = 1 << L1_AW;
  localparam logic [IMG_AW-1:0] IMG_LAST = '1;
  localparam logic [L1_AW-1:0]  L1_LAST  = '1;
  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_L0   = 3'd4,
    S_DUMP_L1   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [IMG_AW-1:0] load_cnt_q, load_cnt_d;
  logic              load_full_q, load_full_d;
  logic [IMG_AW-1:0] ptr_q, ptr_d;
  logic              wr_err_q, wr_err_d;

  logic [DW-1:0] image_mem [IMG_DEPTH];
  logic [DW-1:0] l0_mem    [IMG_DEPTH];
  logic [DW-1:0] l1_mem    [L1_DEPTH];

  logic wr_allowed_s, l0_wr_s, l1_wr_s, wr_bad_s, img_wr_s;
  logic dump_valid_s, dump_fire_s;

  // Decode write legality and dump acceptance for the current cycle.
  always_comb begin
    wr_allowed_s = (state_q != S_DUMP_L0) && (state_q != S_DUMP_L1) && (state_q != S_DONE);
    l0_wr_s  = bus.cwr && wr_allowed_s && (bus.csel == CSEL_L0);
    l1_wr_s  = bus.cwr && wr_allowed_s && (bus.csel == CSEL_L1) &&
               (bus.caddr_wr[IMG_AW-1:L1_AW] == '0);
    wr_bad_s = bus.cwr && !(l0_wr_s || l1_wr_s);
    img_wr_s = (state_q == S_LOAD) && bus.load_valid;
    dump_valid_s = (state_q == S_DUMP_L0) || (state_q == S_DUMP_L1);
    dump_fire_s  = dump_valid_s && bus.dump_ready;
  end

  // Next-state, load counter, dump pointer and sticky flag logic.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    load_full_d = load_full_q;
    ptr_d       = ptr_q;
    wr_err_d    = wr_err_q | wr_bad_s;
    case (state_q)
      S_LOAD: begin
        if (img_wr_s) begin
          load_cnt_d  = load_cnt_q + 1'b1;
          load_full_d = load_full_q | (load_cnt_q == IMG_LAST);
        end else begin
          load_cnt_d  = load_cnt_q;
        end
        if (bus.go) state_d = S_START;
        else        state_d = S_LOAD;
      end
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.busy) state_d = S_RUN;
        else          state_d = S_WAIT_BUSY;
      end
      S_RUN: begin
        if (!bus.busy) state_d = S_DUMP_L0;
        else           state_d = S_RUN;
      end
      S_DUMP_L0: begin
        if (dump_fire_s && (ptr_q == IMG_LAST)) begin
          ptr_d   = '0;
          state_d = S_DUMP_L1;
        end else if (dump_fire_s) begin
          ptr_d   = ptr_q + 1'b1;
        end else begin
          ptr_d   = ptr_q;
        end
      end
      S_DUMP_L1: begin
        if (dump_fire_s && (ptr_q[L1_AW-1:0] == L1_LAST)) begin
          ptr_d   = '0;
          state_d = S_DONE;
        end else if (dump_fire_s) begin
          ptr_d   = ptr_q + 1'b1;
        end else begin
          ptr_d   = ptr_q;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      load_full_q <= 1'b0;
      ptr_q       <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      load_full_q <= load_full_d;
      ptr_q       <= ptr_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Image RAM write port, fed by the loader; contents survive reset.
  always_ff @(posedge clk) begin
    if (img_wr_s) image_mem[load_cnt_q] <= bus.load_data;
  end

  // Layer-0 result RAM write port.
  always_ff @(posedge clk) begin
    if (l0_wr_s) l0_mem[bus.caddr_wr] <= bus.cdata_wr;
  end

  // Layer-1 result RAM write port (only the low address bits index it).
  always_ff @(posedge clk) begin
    if (l1_wr_s) l1_mem[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
  end

  // Asynchronous read ports and status outputs decoded from registered state.
  always_comb begin
    bus.idata      = image_mem[bus.iaddr];
    bus.cdata_rd   = '0;
    bus.dump_data  = '0;
    if (bus.crd && (bus.csel == CSEL_L0))      bus.cdata_rd = l0_mem[bus.caddr_rd];
    else if (bus.crd && (bus.csel == CSEL_L1)) bus.cdata_rd = l1_mem[bus.caddr_rd[L1_AW-1:0]];
    else                                       bus.cdata_rd = '0;
    if (state_q == S_DUMP_L0)      bus.dump_data = l0_mem[ptr_q];
    else if (state_q == S_DUMP_L1) bus.dump_data = l1_mem[ptr_q[L1_AW-1:0]];
    else                           bus.dump_data = '0;
    bus.ready      = (state_q == S_START);
    bus.load_full  = load_full_q;
    bus.dump_valid = dump_valid_s;
    bus.dump_sel   = (state_q == S_DUMP_L1);
    bus.dump_addr  = ptr_q;
    bus.dump_last  = (state_q == S_DUMP_L1) && (ptr_q[L1_AW-1:0] == L1_LAST);
    bus.done       = (state_q == S_DONE);
    bus.wr_err     = wr_err_q;
  end

endmodule

// File: tb/tb_conv_layer_mem_host.sv
// Self-checking bench for conv_layer_mem_host: loads the image, fills the
// result banks, runs the start handshake and checks every dump word against
// reference arrays kept here.
module tb_conv_layer_mem_host;

  typedef struct packed {
    logic        sel;
    logic [11:0] addr;
    logic [19:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [19:0] img_m [4096];
  logic [19:0] l0_m  [4096];
  logic [19:0] l1_m  [1024];
  beat_t       exp_q [$];

  always #5 clk = ~clk;

  conv_layer_mem_host_if bus ();

  conv_layer_mem_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    bus.go = 1'b0; bus.busy = 1'b0; bus.cwr = 1'b0; bus.crd = 1'b0;
    bus.load_valid = 1'b0; bus.dump_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    checks++;
    if ({bus.ready, bus.load_full, bus.dump_valid, bus.dump_sel, bus.dump_last, bus.done, bus.wr_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy/full/dv/sel/last/done/err=%b required 0000000",
               {bus.ready, bus.load_full, bus.dump_valid, bus.dump_sel, bus.dump_last, bus.done, bus.wr_err});
    end
    checks++;
    if (bus.dump_addr !== 12'd0) begin
      errors++; $display("FAIL reset_dump_addr: got %0d required 0", bus.dump_addr);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 4096; i++) begin
      cyc();
      while ($urandom_range(0, 4) == 0) begin
        bus.load_valid = 1'b0;
        cyc();
      end
      bus.load_valid = 1'b1;
      bus.load_data  = 20'(i);
      img_m[i]       = 20'(i);
      if (i == 4095) begin
        settle();
        checks++;
        if (bus.load_full !== 1'b0) begin
          errors++; $display("FAIL load_full_early: got %b required 0", bus.load_full);
        end
      end
    end
    cyc();
    bus.load_valid = 1'b0;
    bus.iaddr = 12'hABC;
    settle();
    checks++;
    if (bus.load_full !== 1'b1) begin
      errors++; $display("FAIL load_full_set: got %b required 1", bus.load_full);
    end
    checks++;
    if (bus.idata !== 20'h00ABC) begin
      errors++; $display("FAIL idata_abc: got %h required 00abc", bus.idata);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      bus.iaddr = 12'($urandom_range(0, 4095));
      settle();
      checks++;
      if (bus.idata !== img_m[bus.iaddr]) begin
        errors++; $display("FAIL idata_rand: addr %h got %h required %h", bus.iaddr, bus.idata, img_m[bus.iaddr]);
      end
    end
    // One more word wraps to address 0.
    cyc();
    bus.load_valid = 1'b1;
    bus.load_data  = 20'hFFFFF;
    img_m[0]       = 20'hFFFFF;
    cyc();
    bus.load_valid = 1'b0;
    bus.iaddr = 12'd0;
    settle();
    checks++;
    if (bus.idata !== img_m[0] || bus.load_full !== 1'b1) begin
      errors++; $display("FAIL load_wrap: got idata %h full %b required %h full 1", bus.idata, bus.load_full, img_m[0]);
    end
  endtask

  task automatic test_layer_rw();
    logic [19:0] d;
    int a;
    for (int i = 0; i < 4096; i++) begin
      cyc();
      d = 20'($urandom);
      bus.cwr = 1'b1; bus.csel = 3'b001; bus.caddr_wr = 12'(i); bus.cdata_wr = d;
      l0_m[i] = d;
    end
    for (int i = 0; i < 1024; i++) begin
      cyc();
      d = 20'($urandom);
      bus.cwr = 1'b1; bus.csel = 3'b011; bus.caddr_wr = 12'(i); bus.cdata_wr = d;
      l1_m[i] = d;
    end
    for (int k = 0; k < 16; k++) begin
      cyc();
      bus.cwr = 1'b0; bus.crd = 1'b1;
      if (k % 2 == 0) begin
        a = $urandom_range(0, 4095); bus.csel = 3'b001; d = l0_m[a];
      end else begin
        a = $urandom_range(0, 1023); bus.csel = 3'b011; d = l1_m[a];
      end
      bus.caddr_rd = 12'(a);
      settle();
      checks++;
      if (bus.cdata_rd !== d) begin
        errors++; $display("FAIL layer_read: csel %b addr %0d got %h required %h", bus.csel, a, bus.cdata_rd, d);
      end
    end
    // Same-address read and write: old value now, new value next cycle.
    cyc();
    bus.cwr = 1'b1; bus.csel = 3'b001; bus.caddr_wr = 12'd5; bus.cdata_wr = 20'h12345;
    bus.crd = 1'b1; bus.caddr_rd = 12'd5;
    settle();
    checks++;
    if (bus.cdata_rd !== l0_m[5]) begin
      errors++; $display("FAIL raw_old: got %h required %h", bus.cdata_rd, l0_m[5]);
    end
    l0_m[5] = 20'h12345;
    cyc();
    bus.cwr = 1'b0;
    settle();
    checks++;
    if (bus.cdata_rd !== 20'h12345) begin
      errors++; $display("FAIL raw_new: got %h required 12345", bus.cdata_rd);
    end
    cyc();
    bus.crd = 1'b0;
    settle();
    checks++;
    if (bus.cdata_rd !== 20'd0 || bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL rd_idle: got data %h err %b required 0 and 0", bus.cdata_rd, bus.wr_err);
    end
    // Out-of-range L1 write.
    cyc();
    bus.cwr = 1'b1; bus.csel = 3'b011; bus.caddr_wr = 12'h400; bus.cdata_wr = ~l1_m[0];
    cyc();
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd0;
    settle();
    checks++;
    if (bus.wr_err !== 1'b1 || bus.cdata_rd !== l1_m[0]) begin
      errors++; $display("FAIL l1_range: got err %b L1[0] %h required 1 and %h", bus.wr_err, bus.cdata_rd, l1_m[0]);
    end
    // Unknown bank select.
    cyc();
    bus.cwr = 1'b1; bus.csel = 3'b010; bus.caddr_wr = 12'd7; bus.cdata_wr = ~l0_m[7];
    bus.crd = 1'b0;
    cyc();
    bus.cwr = 1'b0; bus.crd = 1'b1; bus.csel = 3'b001; bus.caddr_rd = 12'd7;
    settle();
    checks++;
    if (bus.wr_err !== 1'b1 || bus.cdata_rd !== l0_m[7]) begin
      errors++; $display("FAIL bad_csel: got err %b L0[7] %h required 1 and %h", bus.wr_err, bus.cdata_rd, l0_m[7]);
    end
    cyc();
    bus.csel = 3'b010;
    settle();
    checks++;
    if (bus.cdata_rd !== 20'd0) begin
      errors++; $display("FAIL rd_bad_csel: got %h required 0", bus.cdata_rd);
    end
    bus.crd = 1'b0;
  endtask

  task automatic test_start(input bit busy_early);
    int a;
    logic [19:0] d;
    cyc();
    bus.go = 1'b1; bus.busy = busy_early;
    settle();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL ready_before: got %b required 0", bus.ready);
    end
    cyc();
    bus.go = 1'b0;
    settle();
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL ready_pulse: got %b required 1", bus.ready);
    end
    cyc();
    settle();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL ready_after: got %b required 0", bus.ready);
    end
    for (int c = 0; c < 100; c++) begin
      cyc();
      bus.busy = 1'b1;
      bus.load_valid = 1'b1; bus.load_data = 20'($urandom);
      d = 20'($urandom);
      bus.cdata_wr = d;
      if ($urandom_range(0, 1) == 1) begin
        bus.cwr = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 4095); bus.csel = 3'b001; bus.caddr_wr = 12'(a); l0_m[a] = d;
        end else begin
          a = $urandom_range(0, 1023); bus.csel = 3'b011; bus.caddr_wr = 12'(a); l1_m[a] = d;
        end
      end else begin
        bus.cwr = 1'b0;
      end
    end
    cyc();
    bus.busy = 1'b0; bus.cwr = 1'b0; bus.load_valid = 1'b0; bus.iaddr = 12'd1;
    settle();
    checks++;
    if (bus.idata !== img_m[1] || bus.dump_valid !== 1'b0) begin
      errors++; $display("FAIL run_phase: got idata %h dv %b required %h and 0", bus.idata, bus.dump_valid, img_m[1]);
    end
  endtask

  task automatic test_dump(input bit rand_ready, input int stop_at, output bit stopped);
    beat_t got, prev;
    bit    started, have_prev, injected;
    int    cycles, valid_cycles;
    exp_q.delete();
    for (int a = 0; a < 4096; a++) exp_q.push_back({1'b0, 12'(a), l0_m[a]});
    for (int a = 0; a < 1024; a++) exp_q.push_back({1'b1, 12'(a), l1_m[a]});
    stopped = 1'b0; started = 1'b0; have_prev = 1'b0; injected = 1'b0;
    cycles = 0; valid_cycles = 0;
    while (exp_q.size() > 0 && cycles < 20000) begin
      cyc();
      bus.cwr = 1'b0;
      bus.dump_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (started && !injected) begin
        bus.cwr = 1'b1; bus.csel = 3'b001; bus.caddr_wr = 12'd4000; bus.cdata_wr = ~l0_m[4000];
        injected = 1'b1;
      end
      settle();
      cycles++;
      if (stop_at >= 0 && bus.dump_valid && bus.dump_sel && bus.dump_addr == 12'(stop_at)) begin
        stopped = 1'b1;
        break;
      end
      if (started || bus.dump_valid) begin
        started = 1'b1;
        valid_cycles++;
        checks++;
        if (bus.dump_valid !== 1'b1) begin
          errors++; $display("FAIL dump_gap: dump_valid %b with %0d words left", bus.dump_valid, exp_q.size());
        end else begin
          got = {bus.dump_sel, bus.dump_addr, bus.dump_data};
          checks++;
          if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL dump_word: got sel %b addr %0d data %h required sel %b addr %0d data %h",
                     got.sel, got.addr, got.data, exp_q[0].sel, exp_q[0].addr, exp_q[0].data);
          end
          checks++;
          if (bus.dump_last !== (exp_q.size() == 1)) begin
            errors++; $display("FAIL dump_last: got %b at addr %0d sel %b", bus.dump_last, got.addr, got.sel);
          end
          if (have_prev) begin
            checks++;
            if (got !== prev) begin
              errors++; $display("FAIL dump_stall: got %h required %h", got, prev);
            end
          end
          if (bus.dump_ready) begin
            void'(exp_q.pop_front());
            have_prev = 1'b0;
          end else begin
            prev = got;
            have_prev = 1'b1;
          end
        end
      end
    end
    if (!stopped) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL dump_timeout: %0d words left, required 0", exp_q.size());
      end
      if (!rand_ready) begin
        checks++;
        if (valid_cycles != 5120) begin
          errors++; $display("FAIL dump_beats: got %0d cycles required 5120", valid_cycles);
        end
      end
      cyc();
      settle();
      checks++;
      if (bus.done !== 1'b1 || bus.dump_valid !== 1'b0 || bus.dump_last !== 1'b0 || bus.wr_err !== 1'b1) begin
        errors++; $display("FAIL dump_done: got done %b dv %b last %b err %b required 1 0 0 1",
                           bus.done, bus.dump_valid, bus.dump_last, bus.wr_err);
      end
    end
  endtask

  task automatic test_done_hold();
    cyc();
    bus.go = 1'b1;
    cyc();
    bus.go = 1'b0;
    cyc();
    settle();
    checks++;
    if (bus.done !== 1'b1 || bus.ready !== 1'b0 || bus.dump_valid !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done %b ready %b dv %b required 1 0 0", bus.done, bus.ready, bus.dump_valid);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.dump_ready = 1'b0;
    settle();
    checks++;
    if ({bus.dump_valid, bus.done, bus.load_full, bus.dump_sel, bus.dump_last, bus.wr_err} !== 6'b0 ||
        bus.dump_addr !== 12'd0) begin
      errors++; $display("FAIL abort_flags: got dv/done/full/sel/last/err=%b addr %0d required 000000 addr 0",
                         {bus.dump_valid, bus.done, bus.load_full, bus.dump_sel, bus.dump_last, bus.wr_err}, bus.dump_addr);
    end
    // Loader is live again and starts at address 0.
    bus.load_valid = 1'b1; bus.load_data = 20'h5A5A5; img_m[0] = 20'h5A5A5;
    cyc();
    bus.load_valid = 1'b0; bus.iaddr = 12'd0;
    settle();
    checks++;
    if (bus.idata !== img_m[0]) begin
      errors++; $display("FAIL abort_load: got %h required %h", bus.idata, img_m[0]);
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      a = $urandom_range(0, 4095);
      bus.crd = 1'b1; bus.csel = 3'b001; bus.caddr_rd = 12'(a);
      settle();
      checks++;
      if (bus.cdata_rd !== l0_m[a]) begin
        errors++; $display("FAIL abort_l0_keep: addr %0d got %h required %h", a, bus.cdata_rd, l0_m[a]);
      end
    end
    bus.crd = 1'b0;
  endtask

  initial begin
    bit stopped;
    bus.go = 1'b0; bus.busy = 1'b0; bus.iaddr = 12'd0;
    bus.cwr = 1'b0; bus.caddr_wr = 12'd0; bus.cdata_wr = 20'd0;
    bus.crd = 1'b0; bus.caddr_rd = 12'd0; bus.csel = 3'b000;
    bus.load_valid = 1'b0; bus.load_data = 20'd0; bus.dump_ready = 1'b0;

    test_reset();
    test_load();
    test_layer_rw();
    test_start(1'b0);
    test_dump(1'b0, -1, stopped);
    test_done_hold();

    test_reset();
    test_start(1'b1);
    test_dump(1'b1, -1, stopped);

    test_reset();
    test_start(1'b0);
    checks++;
    if (bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL wr_err_cleared: got %b required 0", bus.wr_err);
    end
    test_dump(1'b0, 200, stopped);
    checks++;
    if (stopped !== 1'b1 || bus.wr_err !== 1'b1) begin
      errors++; $display("FAIL dump_l1_200: got reached %b err %b required 1 and 1", stopped, bus.wr_err);
    end
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
